// File: rtl/fir_mac_scheduler.sv
// rtl/fir_mac_scheduler.sv - sequencer for the shared single-multiplier FIR MAC datapath
// Walks NTaps sample/coef address pairs per sample and arbitrates coefficient RAM writes.
module fir_mac_scheduler #(
   parameter int NTaps     = 9,
   parameter int AddrWidth = $clog2(NTaps)
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 sampleValid,
   output logic                 busy,
   output logic                 overrun,
   output logic                 sampleWe,
   output logic [AddrWidth-1:0] sampleWrAddr,
   output logic [AddrWidth-1:0] sampleRdAddr,
   output logic [AddrWidth-1:0] coefAddr,
   output logic                 coefWe,
   input  logic                 coefWrReq,
   input  logic [AddrWidth-1:0] coefWrAddr,
   output logic                 coefWrAck,
   output logic                 macClear,
   output logic                 macEn,
   output logic                 resultValid
);

   typedef enum logic [2:0] {IDLE, WRITE, MAC, DRAIN, DONE} state_t;

   localparam logic [AddrWidth:0]   NTAPS_W = (AddrWidth+1)'(NTaps);
   localparam logic [AddrWidth-1:0] NTAPS_A = AddrWidth'(NTaps);
   localparam logic [AddrWidth-1:0] LAST_K  = AddrWidth'(NTaps - 1);

   state_t               state;
   logic [AddrWidth-1:0] head;
   logic [AddrWidth-1:0] k;
   logic                 coef_grant;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state    <= IDLE;
         head     <= '0;
         k        <= '0;
         macEn    <= 1'b0;
         macClear <= 1'b0;
         overrun  <= 1'b0;
      end else begin
         // Delayed by one cycle so the strobes line up with the RAM read data.
         macEn    <= (state == MAC);
         macClear <= (state == MAC) && (k == '0);
         overrun  <= sampleValid && (state != IDLE);
         case (state)
            IDLE: begin
               if (sampleValid) state <= WRITE;
            end
            WRITE: begin
               k     <= '0;
               state <= MAC;
            end
            MAC: begin
               if (k == LAST_K) begin
                  k     <= '0;
                  state <= DRAIN;
               end else begin
                  k <= k + 1'b1;
               end
            end
            DRAIN: state <= DONE;
            DONE: begin
               head  <= (head == LAST_K) ? '0 : head + 1'b1;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   // A pending sample always wins over the SPI loader in IDLE.
   assign coef_grant = !reset && (state == IDLE) && !sampleValid && coefWrReq;

   assign busy         = (state != IDLE);
   assign resultValid  = (state == DONE);
   assign sampleWe     = (state == WRITE);
   assign sampleWrAddr = (state == WRITE) ? head : '0;
   assign coefWrAck    = coef_grant;
   assign coefWe       = coef_grant && ({1'b0, coefWrAddr} < NTAPS_W);

   // head - k modulo NTaps; the wrapped subtraction is corrected by adding NTaps.
   assign sampleRdAddr = (state != MAC) ? '0 :
                         (head >= k)    ? head - k : head - k + NTAPS_A;

   assign coefAddr = (state == MAC) ? k :
                     coef_grant     ? coefWrAddr : '0;

endmodule

// File: tb/tb_fir_mac_scheduler.sv
// tb/tb_fir_mac_scheduler.sv - directed self-checking bench for fir_mac_scheduler
module tb_fir_mac_scheduler;

   localparam int NT = 9;
   localparam int AW = 4;

   logic          clk = 1'b0;
   logic          reset;
   logic          sampleValid;
   logic          busy;
   logic          overrun;
   logic          sampleWe;
   logic [AW-1:0] sampleWrAddr;
   logic [AW-1:0] sampleRdAddr;
   logic [AW-1:0] coefAddr;
   logic          coefWe;
   logic          coefWrReq;
   logic [AW-1:0] coefWrAddr;
   logic          coefWrAck;
   logic          macClear;
   logic          macEn;
   logic          resultValid;

   int n_vec = 0;
   int n_err = 0;

   fir_mac_scheduler #(.NTaps(NT)) dut (
      .clk(clk), .reset(reset), .sampleValid(sampleValid), .busy(busy),
      .overrun(overrun), .sampleWe(sampleWe), .sampleWrAddr(sampleWrAddr),
      .sampleRdAddr(sampleRdAddr), .coefAddr(coefAddr), .coefWe(coefWe),
      .coefWrReq(coefWrReq), .coefWrAddr(coefWrAddr), .coefWrAck(coefWrAck),
      .macClear(macClear), .macEn(macEn), .resultValid(resultValid)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      sampleValid = 1'b0;
      coefWrReq = 1'b0;
      coefWrAddr = '0;
      tick();
      tick();
      reset = 1'b0;
   endtask

   task automatic test_reset();
      logic [19:0] outs;
      reset = 1'b1;
      sampleValid = 1'b0;
      coefWrReq = 1'b1;
      coefWrAddr = 4'd2;
      tick();
      @(negedge clk);
      outs = {busy, overrun, sampleWe, coefWe, coefWrAck, macClear, macEn, resultValid,
              sampleWrAddr, sampleRdAddr, coefAddr};
      n_vec++;
      if (outs !== 20'h0) begin
         n_err++;
         $display("FAIL reset_outputs: got %h expected 00000", outs);
      end
      do_reset();
   endtask

   task automatic test_single();
      logic [AW-1:0] exp_rd, exp_ca;
      do_reset();
      for (int c = 0; c < 14; c++) begin
         sampleValid = (c == 0);
         exp_rd = (c >= 2 && c <= 10) ? AW'((NT - (c - 2)) % NT) : '0;
         exp_ca = (c >= 2 && c <= 10) ? AW'(c - 2) : '0;
         @(negedge clk);
         n_vec += 8;
         if (sampleWe !== (c == 1)) begin
            n_err++; $display("FAIL single_we c=%0d: got %b expected %b", c, sampleWe, c == 1);
         end
         if (sampleWrAddr !== 4'd0) begin
            n_err++; $display("FAIL single_wraddr c=%0d: got %0d expected 0", c, sampleWrAddr);
         end
         if (sampleRdAddr !== exp_rd) begin
            n_err++; $display("FAIL single_rdaddr c=%0d: got %0d expected %0d", c, sampleRdAddr, exp_rd);
         end
         if (coefAddr !== exp_ca) begin
            n_err++; $display("FAIL single_coefaddr c=%0d: got %0d expected %0d", c, coefAddr, exp_ca);
         end
         if (macClear !== (c == 3)) begin
            n_err++; $display("FAIL single_clear c=%0d: got %b expected %b", c, macClear, c == 3);
         end
         if (macEn !== (c >= 3 && c <= 11)) begin
            n_err++; $display("FAIL single_en c=%0d: got %b expected %b", c, macEn, c >= 3 && c <= 11);
         end
         if (resultValid !== (c == 12)) begin
            n_err++; $display("FAIL single_result c=%0d: got %b expected %b", c, resultValid, c == 12);
         end
         if (busy !== (c >= 1 && c <= 12)) begin
            n_err++; $display("FAIL single_busy c=%0d: got %b expected %b", c, busy, c >= 1 && c <= 12);
         end
         tick();
      end
      sampleValid = 1'b1;
      tick();
      sampleValid = 1'b0;
      @(negedge clk);
      n_vec++;
      if (sampleWrAddr !== 4'd1) begin
         n_err++; $display("FAIL single_head_after: got %0d expected 1", sampleWrAddr);
      end
      for (int c = 0; c < 13; c++) tick();
   endtask

   task automatic test_wrap();
      logic [AW-1:0] exp_rd;
      do_reset();
      for (int s = 0; s < 10; s++) begin
         for (int c = 0; c < 13; c++) begin
            sampleValid = (c == 0);
            exp_rd = AW'((NT - (c - 2)) % NT);
            @(negedge clk);
            n_vec++;
            if (overrun !== 1'b0) begin
               n_err++; $display("FAIL wrap_overrun s=%0d c=%0d: got %b expected 0", s, c, overrun);
            end
            if (c == 1) begin
               n_vec++;
               if (sampleWrAddr !== AW'(s % NT)) begin
                  n_err++; $display("FAIL wrap_wraddr s=%0d: got %0d expected %0d", s, sampleWrAddr, s % NT);
               end
            end
            if (s == 9 && c >= 2 && c <= 10) begin
               n_vec++;
               if (sampleRdAddr !== exp_rd) begin
                  n_err++; $display("FAIL wrap_rdaddr c=%0d: got %0d expected %0d", c, sampleRdAddr, exp_rd);
               end
            end
            tick();
         end
      end
   endtask

   task automatic test_overrun();
      do_reset();
      for (int c = 0; c < 15; c++) begin
         sampleValid = (c == 0 || c == 5);
         @(negedge clk);
         n_vec += 3;
         if (overrun !== (c == 6)) begin
            n_err++; $display("FAIL ovr_pulse c=%0d: got %b expected %b", c, overrun, c == 6);
         end
         if (resultValid !== (c == 12)) begin
            n_err++; $display("FAIL ovr_result c=%0d: got %b expected %b", c, resultValid, c == 12);
         end
         if (sampleWe !== (c == 1)) begin
            n_err++; $display("FAIL ovr_we c=%0d: got %b expected %b", c, sampleWe, c == 1);
         end
         tick();
      end
   endtask

   task automatic test_coef_priority();
      do_reset();
      coefWrReq = 1'b1;
      coefWrAddr = 4'd3;
      for (int c = 0; c < 14; c++) begin
         sampleValid = (c == 0);
         @(negedge clk);
         n_vec += 2;
         if (coefWrAck !== (c == 13)) begin
            n_err++; $display("FAIL prio_ack c=%0d: got %b expected %b", c, coefWrAck, c == 13);
         end
         if (coefWe !== (c == 13)) begin
            n_err++; $display("FAIL prio_we c=%0d: got %b expected %b", c, coefWe, c == 13);
         end
         if (c == 13) begin
            n_vec++;
            if (coefAddr !== 4'd3) begin
               n_err++; $display("FAIL prio_addr: got %0d expected 3", coefAddr);
            end
         end
         tick();
      end
      coefWrReq = 1'b0;
   endtask

   task automatic test_coef_range();
      do_reset();
      coefWrReq = 1'b1;
      coefWrAddr = 4'd12;
      @(negedge clk);
      n_vec += 2;
      if (coefWrAck !== 1'b1) begin
         n_err++; $display("FAIL range_ack12: got %b expected 1", coefWrAck);
      end
      if (coefWe !== 1'b0) begin
         n_err++; $display("FAIL range_we12: got %b expected 0", coefWe);
      end
      tick();
      coefWrAddr = 4'd8;
      @(negedge clk);
      n_vec += 3;
      if (coefWrAck !== 1'b1) begin
         n_err++; $display("FAIL range_ack8: got %b expected 1", coefWrAck);
      end
      if (coefWe !== 1'b1) begin
         n_err++; $display("FAIL range_we8: got %b expected 1", coefWe);
      end
      if (coefAddr !== 4'd8) begin
         n_err++; $display("FAIL range_addr8: got %0d expected 8", coefAddr);
      end
      tick();
      coefWrReq = 1'b0;
   endtask

   task automatic test_reset_mid();
      logic [19:0] outs;
      do_reset();
      for (int c = 0; c < 13; c++) begin
         sampleValid = (c == 0);
         tick();
      end
      for (int c = 0; c < 20; c++) begin
         sampleValid = (c == 0);
         reset = (c == 6);
         @(negedge clk);
         if (c == 6) begin
            outs = {busy, overrun, sampleWe, coefWe, coefWrAck, macClear, macEn, resultValid,
                    sampleWrAddr, sampleRdAddr, coefAddr};
            n_vec++;
            if (outs !== 20'h0) begin
               n_err++; $display("FAIL midreset_outputs: got %h expected 00000", outs);
            end
         end
         n_vec++;
         if (resultValid !== 1'b0) begin
            n_err++; $display("FAIL midreset_result c=%0d: got %b expected 0", c, resultValid);
         end
         tick();
      end
      reset = 1'b0;
      sampleValid = 1'b1;
      tick();
      sampleValid = 1'b0;
      @(negedge clk);
      n_vec += 2;
      if (sampleWe !== 1'b1) begin
         n_err++; $display("FAIL midreset_we: got %b expected 1", sampleWe);
      end
      if (sampleWrAddr !== 4'd0) begin
         n_err++; $display("FAIL midreset_wraddr: got %0d expected 0", sampleWrAddr);
      end
      for (int c = 0; c < 13; c++) tick();
   endtask

   initial begin
      reset = 1'b1;
      sampleValid = 1'b0;
      coefWrReq = 1'b0;
      coefWrAddr = '0;
      test_reset();
      test_single();
      test_wrap();
      test_overrun();
      test_coef_priority();
      test_coef_range();
      test_reset_mid();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/fir_mac_scheduler.md
Name: fir_mac_scheduler

Overview:
Sequences the shared single-multiplier MAC datapath of the FIR engine. For each incoming audio sample, it writes the sample into a circular sample buffer and then walks NTaps (sample, coefficient) address pairs. It generates aligned MAC enable/clear strobes and signals when the result is ready. It also arbitrates coefficient-RAM write access between the SPI loader and the filter datapath, so coefficients never change mid-convolution.

Parameters:
NTaps, 9, number of filter taps (>=2)
AddrWidth, $clog2(NTaps), width of sample/coefficient addresses

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-high reset
sampleValid  input  1  one-cycle strobe: new ADC sample on the datapath input
busy  output  1  high whenever the state is not IDLE
overrun  output  1  one-cycle pulse: sampleValid arrived while busy; that sample was dropped
sampleWe  output  1  sample buffer write enable
sampleWrAddr  output  AddrWidth  sample buffer write address
sampleRdAddr  output  AddrWidth  sample buffer read address (1-cycle read latency RAM)
coefAddr  output  AddrWidth  coefficient RAM address (shared read/write port)
coefWe  output  1  coefficient RAM write enable
coefWrReq  input  1  SPI loader write request (already clk-synchronous), held until acked
coefWrAddr  input  AddrWidth  SPI loader target tap index
coefWrAck  output  1  one-cycle grant: write performed this cycle
macClear  output  1  load accumulator with product instead of adding
macEn  output  1  accumulate product of current RAM read data
resultValid  output  1  one-cycle pulse: accumulator holds the finished output sample

Behaviour:
- Reset: state=IDLE, head=0, tap counter=0. All outputs 0: busy, overrun, sampleWe, coefWe, coefWrAck, macClear, macEn, resultValid, and all addresses.
- States: IDLE -> WRITE -> MAC -> DRAIN -> DONE -> IDLE.
- IDLE, sampleValid=1: go to WRITE. Sample has priority over coefWrReq in the same cycle; the request stays pending.
- IDLE, sampleValid=0, coefWrReq=1:
  - coefWe=1, coefAddr=coefWrAddr, coefWrAck=1, all in the same cycle; stay in IDLE.
  - If coefWrAddr>=NTaps: ack is still given, coefWe=0.
- WRITE (1 cycle): sampleWe=1, sampleWrAddr=head; go to MAC with k=0.
- MAC (NTaps cycles, k=0..NTaps-1):
  - sampleRdAddr=(head+NTaps-k) mod NTaps, coefAddr=k.
  - After k=NTaps-1, go to DRAIN.
- macEn is the 1-cycle delay of "state==MAC". macClear is the 1-cycle delay of "state==MAC && k==0". Both strobes therefore line up with RAM read data.
- DRAIN (1 cycle): last macEn is active; no new addresses.
- DONE (1 cycle): resultValid=1; head<=(head+1) mod NTaps, wrapping NTaps-1 -> 0; go to IDLE.
- Latency: sampleValid at cycle T gives:
  - sampleWe at T+1;
  - macEn T+3..T+2+NTaps, macClear at T+3;
  - resultValid at T+NTaps+3 (T+12 for NTaps=9).
  - Minimum sample spacing is NTaps+4 cycles.
- sampleValid in any non-IDLE state (including the DONE cycle): sample is ignored, overrun pulses the next cycle, sequencing is unaffected.
- coefWrReq outside IDLE: no ack and coefWe=0; the request waits. Coefficients are never written between WRITE and DONE.
- coefAddr outside IDLE/MAC holds 0. sampleRdAddr outside MAC holds 0.
- busy=1 in WRITE, MAC, DRAIN and DONE.
- Reset asserted mid-operation: immediate return to IDLE and reset values. No resultValid pulse; the partial accumulation is abandoned; head returns to 0.

Test Plan:
- Reset, then one sampleValid at T=10 with NTaps=9:
  - sampleWe at 11 with wrAddr 0;
  - rdAddr sequence 0,8,7,6,5,4,3,2,1 on cycles 12..20, coefAddr 0..8;
  - macClear at 13 only, macEn 13..21, resultValid at 22;
  - head=1 afterwards.
- 10 samples spaced 13 cycles apart: sampleWrAddr goes 0..8 then 0 (wrap). The 10th pass reads 0,8,7,...,1; no overrun.
- sampleValid at T and again at T+5: second sample dropped, overrun pulses at T+6, single resultValid at T+12.
- sampleValid and coefWrReq (addr 3) together in IDLE:
  - sample is serviced first, coefWrAck=0 throughout;
  - ack and coefWe with coefAddr=3 land in the first IDLE cycle after DONE.
- coefWrReq with addr 12 in IDLE: coefWrAck=1, coefWe=0.
- Reset pulse at T+6 during MAC: all outputs 0 next edge, no resultValid. Next sample writes address 0.
